// File: rtl/pulse_tick_counter.sv
// Synchronises clk_N, emits one tick per rising edge and keeps a BCD count while running.
// Optional lap capture registers are built when PULSE_TICK_COUNTER_LAP_EN is defined.
module pulse_tick_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_TENS    = 5
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clk_N,
  input  logic       start_stop,
  input  logic       clear,
  output logic       tick,
  output logic       running,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry
`ifdef PULSE_TICK_COUNTER_LAP_EN
  ,
  input  logic       lap,
  output logic [3:0] lap_ones,
  output logic [3:0] lap_tens
`endif
);

  // state | meaning
  // IDLE  | count zeroed, waiting for start_stop
  // RUN   | count advances on every tick
  // PAUSE | count frozen, start_stop resumes
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int         FILL_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [3:0] MAX_TENS_L = 4'(MAX_TENS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   hist_q, hist_d;
  logic                   arm_q, arm_d;
  logic                   tick_q, tick_d;
  logic                   sync_out;

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       carry_q, carry_d;
  logic       running_q, running_d;
`ifdef PULSE_TICK_COUNTER_LAP_EN
  logic [3:0] lap_ones_q, lap_ones_d;
  logic [3:0] lap_tens_q, lap_tens_d;
`endif

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edge detect is armed only after a genuinely sampled low, so a clk_N held
  // high through reset release cannot look like a rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_N};
    fill_d = (fill_q != '0) ? fill_q - 1'b1 : fill_q;
    hist_d = sync_out;
    arm_d  = arm_q | ((fill_q == '0) && !sync_out);
    tick_d = arm_q & sync_out & ~hist_q;
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
`ifdef PULSE_TICK_COUNTER_LAP_EN
    lap_ones_d = lap_ones_q;
    lap_tens_d = lap_tens_q;
`endif
    if (clear) begin
      state_d = IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
`ifdef PULSE_TICK_COUNTER_LAP_EN
      lap_ones_d = 4'd0;
      lap_tens_d = 4'd0;
`endif
    end else begin
`ifdef PULSE_TICK_COUNTER_LAP_EN
      if (lap && state_q == RUN) begin
        lap_ones_d = ones_q;
        lap_tens_d = tens_q;
      end
`endif
      if (state_q == RUN && tick_q) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == MAX_TENS_L) begin
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      if (start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      fill_q    <= FILL_W'(SYNC_STAGES);
      hist_q    <= 1'b0;
      arm_q     <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
`ifdef PULSE_TICK_COUNTER_LAP_EN
      lap_ones_q <= 4'd0;
      lap_tens_q <= 4'd0;
`endif
    end else begin
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      hist_q    <= hist_d;
      arm_q     <= arm_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      carry_q   <= carry_d;
      running_q <= running_d;
`ifdef PULSE_TICK_COUNTER_LAP_EN
      lap_ones_q <= lap_ones_d;
      lap_tens_q <= lap_tens_d;
`endif
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign ones    = ones_q;
  assign tens    = tens_q;
  assign carry   = carry_q;
`ifdef PULSE_TICK_COUNTER_LAP_EN
  assign lap_ones = lap_ones_q;
  assign lap_tens = lap_tens_q;
`endif

endmodule

// File: tb/tb_pulse_tick_counter.sv
// Randomised bench for pulse_tick_counter with a count-as-integer reference model.
// Lap checks are compiled in when PULSE_TICK_COUNTER_LAP_EN is defined.
module tb_pulse_tick_counter;
  localparam int MAXT = 5;
  localparam int MOD  = (MAXT + 1) * 10;

  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic clk_N = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic tick, running, carry;
  logic [3:0] ones, tens;
  logic [3:0] lap_ones, lap_tens;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;   // model count 0..MOD-1
  int m_st = 0;    // 0 idle, 1 run, 2 pause
  int m_lap = 0;
  int tick_total = 0;
  int carry_total = 0;

  pulse_tick_counter #(.SYNC_STAGES(2), .MAX_TENS(MAXT)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_N(clk_N), .start_stop(start_stop),
    .clear(clear), .tick(tick), .running(running), .ones(ones), .tens(tens),
    .carry(carry)
`ifdef PULSE_TICK_COUNTER_LAP_EN
    , .lap(lap), .lap_ones(lap_ones), .lap_tens(lap_tens)
`endif
  );

`ifndef PULSE_TICK_COUNTER_LAP_EN
  assign lap_ones = 4'd0;
  assign lap_tens = 4'd0;
`endif

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic model_edge(input bit tk, input bit ss, input bit clr, input bit lp, output bit cy);
    cy = 0;
    if (clr) begin
      m_cnt = 0; m_st = 0; m_lap = 0;
    end else begin
      if (lp && m_st == 1) m_lap = m_cnt;
      if (tk && m_st == 1) begin
        if (m_cnt == MOD - 1) cy = 1;
        m_cnt = (m_cnt + 1) % MOD;
      end
      if (ss) m_st = (m_st == 1) ? 2 : 1;
    end
  endtask

  task automatic cmd(input bit ss, input bit clr, input bit lp);
    bit cy;
    @(negedge clk_in);
    start_stop = ss; clear = clr; lap = lp;
    @(posedge clk_in);
    model_edge(0, ss, clr, lp, cy);
    #1;
    start_stop = 0; clear = 0; lap = 0;
  endtask

  // One clk_N period; optional commands land on the edge where tick is high.
  task automatic rise(input int hi, input int lo, input bit ss, input bit clr, input bit lp);
    bit bad = 0;
    bit cy;
    int exp_c = 0;
    int seen_c = 0;
    int prev = tens * 10 + ones;
    @(posedge clk_in);
    #($urandom_range(2, 8));
    clk_N = 1;
    for (int k = 1; k <= hi; k++) begin
      @(posedge clk_in);
      if (k == 4) begin
        model_edge(1, ss, clr, lp, cy);
        if (cy) exp_c++;
      end
      #1;
      if (tick !== (k == 3)) bad = 1;
      if (tick === 1'b1) tick_total++;
      if (carry === 1'b1) begin
        seen_c++; carry_total++;
        if (prev != MOD - 1) bad = 1;
      end
      prev = tens * 10 + ones;
      if (k == 3) begin start_stop = ss; clear = clr; lap = lp; end
      if (k == 4) begin start_stop = 0; clear = 0; lap = 0; end
    end
    #($urandom_range(1, 7));
    clk_N = 0;
    for (int k = 1; k <= lo; k++) begin
      @(posedge clk_in);
      #1;
      if (tick !== 1'b0) bad = 1;
      if (carry === 1'b1) begin seen_c++; carry_total++; end
    end
    tests++;
    if (bad) begin fails++; $display("FAIL tick_shape observed irregular tick/carry timing, want one tick 3 cycles after rise"); end
    tests++;
    if (seen_c != exp_c) begin fails++; $display("FAIL carry_pulses got %0d want %0d", seen_c, exp_c); end
    tests++;
    if (ones !== 4'(m_cnt % 10) || tens !== 4'(m_cnt / 10) || running !== (m_st == 1)) begin
      fails++;
      $display("FAIL count got %0d%0d run=%b want %0d run=%0d", tens, ones, running, m_cnt, m_st == 1);
    end
`ifdef PULSE_TICK_COUNTER_LAP_EN
    tests++;
    if (lap_tens * 10 + lap_ones != m_lap) begin
      fails++; $display("FAIL lap_reg got %0d%0d want %0d", lap_tens, lap_ones, m_lap);
    end
`endif
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) rise($urandom_range(5, 8), $urandom_range(5, 8), 0, 0, 0);
  endtask

  task automatic do_reset(input bit nval);
    @(negedge clk_in);
    rst_n = 0; clk_N = nval;
    m_cnt = 0; m_st = 0; m_lap = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({tick, running, carry, ones, tens, lap_ones, lap_tens} !== 19'd0) begin
      fails++; $display("FAIL reset_state got t%b r%b c%b %0d%0d want all 0", tick, running, carry, tens, ones);
    end
    @(negedge clk_in); rst_n = 1;
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_idle_ticks;
    tick_total = 0;
    rises(30);
    tests++;
    if (tick_total != 30) begin fails++; $display("FAIL idle_ticks got %0d want 30", tick_total); end
    tests++;
    if (ones !== 0 || tens !== 0 || running !== 0) begin
      fails++; $display("FAIL idle_count got %0d%0d run=%b want 00 run=0", tens, ones, running);
    end
  endtask

  task automatic test_run_12;
    cmd(1, 0, 0);
    rises(12);
    tests++;
    if (running !== 1 || tens !== 1 || ones !== 2) begin
      fails++; $display("FAIL run_12 got %0d%0d run=%b want 12 run=1", tens, ones, running);
    end
  endtask

  task automatic test_wrap;
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    carry_total = 0;
    rises(60);
    tests++;
    if (carry_total != 1 || ones !== 0 || tens !== 0) begin
      fails++; $display("FAIL wrap got %0d%0d carries=%0d want 00 carries=1", tens, ones, carry_total);
    end
  endtask

  task automatic test_pause;
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    rises(7);
    cmd(1, 0, 0);
    rises(5);
    tests++;
    if (ones !== 7 || tens !== 0 || running !== 0) begin
      fails++; $display("FAIL pause_hold got %0d%0d run=%b want 07 run=0", tens, ones, running);
    end
    cmd(1, 0, 0);
    rises(3);
    tests++;
    if (ones !== 0 || tens !== 1) begin fails++; $display("FAIL pause_resume got %0d%0d want 10", tens, ones); end
  endtask

  task automatic test_coincide;
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    rises(45);
    carry_total = 0;
    rise(6, 6, 1, 1, 0);
    tests++;
    if (ones !== 0 || tens !== 0 || running !== 0 || carry_total != 0) begin
      fails++; $display("FAIL clear_tick got %0d%0d run=%b c=%0d want 00 idle c=0", tens, ones, running, carry_total);
    end
    rise(6, 6, 1, 0, 0);
    tests++;
    if (ones !== 0 || running !== 1) begin fails++; $display("FAIL idle_ss_tick got %0d run=%b want 0 run=1", ones, running); end
    rises(3);
    rise(6, 6, 1, 0, 0);
    tests++;
    if (ones !== 4 || running !== 0) begin fails++; $display("FAIL run_ss_tick got %0d run=%b want 4 run=0", ones, running); end
    rise(6, 6, 1, 0, 0);
    tests++;
    if (ones !== 4 || running !== 1) begin fails++; $display("FAIL pause_ss_tick got %0d run=%b want 4 run=1", ones, running); end
  endtask

  task automatic test_random;
    cmd(0, 1, 0);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 5) == 0) cmd($urandom_range(0, 1), 0, $urandom_range(0, 1));
      rise($urandom_range(5, 8), $urandom_range(5, 8), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_reset_mid_run;
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    rises(33);
    @(negedge clk_in);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({tick, running, carry, ones, tens, lap_ones, lap_tens} !== 19'd0) begin
      fails++; $display("FAIL async_reset got r%b %0d%0d want all 0", running, tens, ones);
    end
    m_cnt = 0; m_st = 0; m_lap = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); rst_n = 1;
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_high_at_reset;
    bit bad = 0;
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_in); #1;
      if (tick !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL high_at_reset observed tick=1 want none"); end
    @(posedge clk_in); #3 clk_N = 0;
    repeat (6) @(posedge clk_in);
    tick_total = 0;
    rise(6, 6, 0, 0, 0);
    tests++;
    if (tick_total != 1) begin fails++; $display("FAIL first_tick_after_fall got %0d want 1", tick_total); end
  endtask

`ifdef PULSE_TICK_COUNTER_LAP_EN
  task automatic test_lap;
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    rises(21);
    cmd(0, 0, 1);
    rises(4);
    tests++;
    if (lap_tens !== 2 || lap_ones !== 1 || tens !== 2 || ones !== 5) begin
      fails++; $display("FAIL lap_21 got lap %0d%0d live %0d%0d want lap 21 live 25", lap_tens, lap_ones, tens, ones);
    end
    rise(6, 6, 0, 0, 1);
    cmd(1, 0, 0);
    cmd(0, 0, 1);
    tests++;
    if (lap_tens !== 2 || lap_ones !== 5) begin fails++; $display("FAIL lap_pause got %0d%0d want 25", lap_tens, lap_ones); end
    cmd(0, 1, 0);
    tests++;
    if (lap_tens !== 0 || lap_ones !== 0) begin fails++; $display("FAIL lap_clear got %0d%0d want 00", lap_tens, lap_ones); end
  endtask
`endif

  initial begin
    test_reset;
    test_idle_ticks;
    test_run_12;
    test_wrap;
    test_pause;
    test_coincide;
    test_random;
    test_reset_mid_run;
    test_high_at_reset;
`ifdef PULSE_TICK_COUNTER_LAP_EN
    test_lap;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
